unos_operanada: RTL and testbench

Operand-entry stage directly upstream of the 7-bit adder (`sabiranje`) on the board build. The block samples the 7 slide switches on two debounced presses of a load button, capturing operand A and then operand B, and presents the pair with a valid/ready handshake. The downstream ALU wrapper drives `a` and `b` straight into the adder. A clear button aborts entry at any point.

---
 rtl/unos_operanada_pkg.sv | 17 +
 rtl/unos_operanada_debounce.sv | 59 +++++
 rtl/unos_operanada.sv | 96 +++++++++
 tb/tb_unos_operanada.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/unos_operanada_pkg.sv
// unos_operanada_pkg: shared state encodings and default debounce length
// for the operand-entry stage.
`default_nettype none

package unos_operanada_pkg;

  typedef enum logic [1:0] {
    S_WAIT_A  = 2'd0,
    S_WAIT_B  = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam int DEB_CYCLES_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/unos_operanada_debounce.sv
// debounce: two-flop synchronizer, stability counter and rising-edge detector
// turning a raw bouncy pushbutton into a one-cycle press pulse.
`default_nettype none

module debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             s_q, s_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d    = raw;
    s_d       = meta_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = '0;
    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    if (s_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= 1'b0;
      s_q       <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      meta_q    <= meta_d;
      s_q       <= s_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_dly_q;

endmodule

`default_nettype wire

// File: rtl/unos_operanada.sv
// unos_operanada: captures operands A and B from the switches on two debounced
// load presses and presents them to the adder with a valid/ready handshake.
`default_nettype none

module unos_operanada
  import unos_operanada_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       phase
);

  logic press_load;
  logic press_clr;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .press (press_load)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clr),
    .press (press_clr)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    // Clear overrides everything; a coincident handshake is simply absorbed.
    if (press_clr) begin
      state_d = S_WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        S_WAIT_A: begin
          if (press_load) begin
            a_d     = sw;
            state_d = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (press_load) begin
            b_d     = sw;
            state_d = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (ready) begin
            state_d = S_WAIT_A;
          end
        end
        default: state_d = S_WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = (state_q == S_PRESENT);
  assign phase = state_q;

endmodule

`default_nettype wire

// File: tb/tb_unos_operanada.sv
// tb_unos_operanada: directed + randomized checks of operand entry against a
// small behavioural model of the entry rules.
`default_nettype none

module tb_unos_operanada;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] sw = '0;
  logic       btn_load = 1'b0;
  logic       btn_clr = 1'b0;
  logic       ready = 1'b0;
  logic [6:0] a;
  logic [6:0] b;
  logic       valid;
  logic [1:0] phase;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Behavioural model: operand values and entry phase (0=A, 1=B, 2=present)
  logic [6:0] m_a = '0;
  logic [6:0] m_b = '0;
  int         m_ph = 0;

  unos_operanada dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clr  (btn_clr),
    .a        (a),
    .b        (b),
    .valid    (valid),
    .ready    (ready),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a"}, 32'(a), 32'(m_a));
    chk({tag, "_b"}, 32'(b), 32'(m_b));
    chk({tag, "_phase"}, 32'(phase), 32'(m_ph));
    chk({tag, "_valid"}, 32'(valid), (m_ph == 2) ? 32'd1 : 32'd0);
  endtask

  // One debounced button event applied to the model.
  task automatic model_event(input logic ld, input logic cl);
    if (cl) begin
      m_a = '0; m_b = '0; m_ph = 0;
    end else if (ld) begin
      if (m_ph == 0) begin
        m_a = sw; m_ph = 1;
      end else if (m_ph == 1) begin
        m_b = sw; m_ph = 2;
      end
    end
  endtask

  // Clean hold: nothing happens through edge 6, action lands on edge 7.
  task automatic press(input logic ld, input logic cl, input string tag);
    btn_load = ld;
    btn_clr  = cl;
    tick(6);
    chk_model({tag, "_pre"});
    tick(1);
    model_event(ld, cl);
    chk_model({tag, "_cap"});
    if (m_ph == 2 && ready) begin
      tick(1);
      m_ph = 0;
      chk_model({tag, "_xfer"});
    end
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    tick(8);
    if (m_ph == 2 && ready) m_ph = 0;
    chk_model({tag, "_rel"});
  endtask

  initial begin
    logic [6:0] z;
    int t;
    int d;

    // Reset state
    #12;
    chk_model("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    chk_model("post_reset");

    // Basic entry 45 + 100 with ready held high
    sw = 7'd45;
    press(1'b1, 1'b0, "basicA");
    sw = 7'd100;
    ready = 1'b1;
    press(1'b1, 1'b0, "basicB");
    z = a + b;
    chk("adder_z", 32'(z), 32'd17);
    ready = 1'b0;

    // Bounce rejection: short pulses, always ending low, then a clean hold
    sw = 7'($urandom);
    t = 0;
    while (t < 40) begin
      btn_load = 1'b1;
      d = $urandom_range(1, 3);
      tick(d);
      t += d;
      btn_load = 1'b0;
      d = $urandom_range(1, 3);
      tick(d);
      t += d;
      chk("bounce_phase", 32'(phase), 32'(m_ph));
    end
    press(1'b1, 1'b0, "bounce_hold");

    // Backpressure with switches and load button churning
    sw = 7'($urandom);
    press(1'b1, 1'b0, "bpB");
    for (int i = 0; i < 20; i++) begin
      sw = 7'($urandom);
      btn_load = 1'($urandom);
      tick(1);
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_a", 32'(a), 32'(m_a));
      chk("bp_b", 32'(b), 32'(m_b));
    end
    btn_load = 1'b0;
    tick(10);
    chk_model("bp_settle");
    ready = 1'b1;
    tick(1);
    m_ph = 0;
    chk_model("bp_xfer");
    ready = 1'b0;

    // Randomized entries, random ready, plus ignored load in PRESENT
    for (int i = 0; i < 4; i++) begin
      ready = 1'($urandom);
      sw = 7'($urandom);
      press(1'b1, 1'b0, "rndA");
      sw = 7'($urandom);
      press(1'b1, 1'b0, "rndB");
      if (m_ph == 2) begin
        sw = 7'($urandom);
        press(1'b1, 1'b0, "rnd_ign");
        tick(3);
        chk_model("rnd_hold");
        ready = 1'b1;
        tick(1);
        m_ph = 0;
        chk_model("rnd_xfer");
      end
      ready = 1'b0;
    end

    // Clear in WAIT_B, clear+load together, clear in PRESENT
    sw = 7'd12;
    press(1'b1, 1'b0, "clrA12");
    press(1'b0, 1'b1, "clrB");
    sw = 7'd12;
    press(1'b1, 1'b0, "cl2A12");
    sw = 7'd55;
    press(1'b1, 1'b1, "clr_and_ld");
    sw = 7'($urandom);
    press(1'b1, 1'b0, "clpA");
    sw = 7'($urandom);
    press(1'b1, 1'b0, "clpB");
    press(1'b0, 1'b1, "clrP");

    // Reset mid-entry with load held across deassertion
    sw = 7'($urandom);
    press(1'b1, 1'b0, "rmA");
    btn_load = 1'b1;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    m_a = '0; m_b = '0; m_ph = 0;
    chk_model("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    sw = 7'($urandom);
    tick(6);
    chk_model("rst_rel_pre");
    tick(1);
    model_event(1'b1, 1'b0);
    chk_model("rst_rel_cap");
    btn_load = 1'b0;
    tick(8);
    chk_model("rst_rel_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
